// File: rtl/video_timing_gen.sv
// Raster timing sequencer: walks hc/vc through active/porch/sync regions and
// emits registered de, syncs, coordinates and line/frame markers.
module video_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int X_W      = 12,
   parameter int Y_W      = 11
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   output logic           de,
   output logic           hsync,
   output logic           vsync,
   output logic [1:0]     ctrl,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           line_start,
   output logic           frame_start,
   output logic [7:0]     frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > (1 << X_W) || V_TOTAL > (1 << Y_W)) begin : g_bad_size
      $error("video_timing_gen: raster totals do not fit the counter widths");
   end

   localparam logic [X_W-1:0] H_ACT_END  = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0] H_SYNC_LO  = X_W'(H_ACTIVE + H_FP);
   localparam logic [X_W-1:0] H_SYNC_HI  = X_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
   localparam logic [Y_W-1:0] V_ACT_END  = Y_W'(V_ACTIVE);
   localparam logic [Y_W-1:0] V_SYNC_LO  = Y_W'(V_ACTIVE + V_FP);
   localparam logic [Y_W-1:0] V_SYNC_HI  = Y_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);

   // hc/vc hold the position that the next enabled cycle will emit.
   logic [X_W-1:0] hc_q, hc_d, x_q, x_d;
   logic [Y_W-1:0] vc_q, vc_d, y_q, y_d;
   logic           de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic           line_start_q, line_start_d, frame_start_q, frame_start_d;
   logic [7:0]     frame_count_q, frame_count_d;
   logic           h_active, v_active, h_sync, v_sync;

   always_comb begin
      h_active = hc_q < H_ACT_END;
      v_active = vc_q < V_ACT_END;
      h_sync   = (hc_q >= H_SYNC_LO) && (hc_q < H_SYNC_HI);
      v_sync   = (vc_q >= V_SYNC_LO) && (vc_q < V_SYNC_HI);

      // NOTE: every _d gets a default before any branch so no latch is inferred.
      hc_d          = hc_q;
      vc_d          = vc_q;
      x_d           = x_q;
      y_d           = y_q;
      frame_count_d = frame_count_q;
      de_d          = 1'b0;
      hsync_d       = ~H_POL;
      vsync_d       = ~V_POL;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;

      if (en) begin
         de_d          = h_active && v_active;
         hsync_d       = h_sync ? H_POL : ~H_POL;
         vsync_d       = v_sync ? V_POL : ~V_POL;
         x_d           = hc_q;
         y_d           = vc_q;
         line_start_d  = (hc_q == '0);
         frame_start_d = (hc_q == '0) && (vc_q == '0);
         if (frame_start_d) begin
            frame_count_d = frame_count_q + 8'd1;
         end
         if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + Y_W'(1);
         end else begin
            hc_d = hc_q + X_W'(1);
         end
      end
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         hc_q          <= '0;
         vc_q          <= '0;
         x_q           <= '0;
         y_q           <= '0;
         de_q          <= 1'b0;
         hsync_q       <= ~H_POL;
         vsync_q       <= ~V_POL;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= 8'd0;
      end else begin
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         x_q           <= x_d;
         y_q           <= y_d;
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign de          = de_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign ctrl        = {vsync_q, hsync_q};
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing sequencer for the video controller; drives the three TMDS encoder channels.
- Walks horizontal and vertical counters through active, front porch, sync and back porch regions. Emits de, hsync and vsync, plus a ctrl pair for the blue channel encoder (ctrl = {vsync,hsync}).
- Emits x/y pixel coordinates and line/frame markers for the pixel source upstream of the encoders.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch cycles
- H_SYNC, 96, hsync pulse cycles
- H_BP, 48, horizontal back porch cycles
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch lines
- V_SYNC, 2, vsync pulse lines
- V_BP, 33, vertical back porch lines
- H_POL, 0, active level of hsync
- V_POL, 0, active level of vsync
- X_W, 12, width of horizontal counter and x
- Y_W, 11, width of vertical counter and y

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  advance enable; position advances only in cycles with en=1
- de  out  1  data enable (active video)
- hsync  out  1  horizontal sync at H_POL polarity
- vsync  out  1  vertical sync at V_POL polarity
- ctrl  out  2  {vsync,hsync} line levels, for channel-0 encoder ctrl input
- x  out  X_W  horizontal position of the emitted cycle
- y  out  Y_W  vertical position of the emitted cycle
- line_start  out  1  one-cycle pulse at hc=0 of every line
- frame_start  out  1  one-cycle pulse at hc=0, vc=0
- frame_count  out  8  frames started since reset, wraps 255->0

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. All parameters >=1; H_TOTAL <= 2^X_W and V_TOTAL <= 2^Y_W (elaboration-time assertion).
- Internal hc/vc hold the NEXT position to emit. Reset sets hc=vc=0.
- Each cycle with en=1:
  - Outputs register the decode of (hc,vc).
  - hc advances; at H_TOTAL-1 it wraps to 0 and vc advances.
  - vc wraps to 0 at V_TOTAL-1 when hc wraps.
- Output latency is 1 cycle: position P applied while en=1 at edge k appears on the outputs after edge k.
- Horizontal regions of hc: active [0,H_ACTIVE); FP [H_ACTIVE,+H_FP); SYNC [H_ACTIVE+H_FP,+H_SYNC); BP for the remainder. Vertical regions of vc use the same layout.
- Decode of (hc,vc):
  - de = h_active AND v_active.
  - hsync = H_POL in h_sync region, else ~H_POL; vsync likewise with V_POL.
  - vsync is line-granular: it changes only at hc=0.
  - x=hc, y=vc (x/y are valid during blanking too).
  - line_start = (hc==0); frame_start = (hc==0 && vc==0).
  - frame_count increments on the edge that registers frame_start=1.
- en=0 cycle: hc/vc frozen. Registered outputs become blank: de=0, hsync=~H_POL, vsync=~V_POL, line_start=0, frame_start=0. x, y and frame_count hold. When en returns, emission resumes at the frozen position with no skip and no repeat.
- Reset (any cycle, including mid-frame; overrides en):
  - Outputs become de=0, hsync=~H_POL, vsync=~V_POL, ctrl={~V_POL,~H_POL}, x=0, y=0, line_start=0, frame_start=0, frame_count=0.
  - The first en=1 cycle after release emits (0,0): de=1, line_start=1, frame_start=1, frame_count becomes 1.
- No combinational path from en to any output; all outputs are registers.

Test Plan:
1. Defaults, rst 1->0, en held 1 -> first post-reset emission de=1, x=0, y=0, line_start=1, frame_start=1, frame_count=1; de high 640 consecutive cycles then low 160; line_start period 800.
2. Defaults, one line -> hsync=0 exactly at x=656..751 (96 cycles), 1 elsewhere; ctrl[0] tracks hsync; de=0 throughout x>=640.
3. Defaults, full frame -> vsync=0 for y=490..491, asserting at x=0 of y=490 and lasting 1600 cycles; de never 1 for y>=480; frame_start period 420000 cycles; frame_count 1->2 at second frame_start.
4. en dropped for 5 cycles while the next position is x=100,y=3 -> 5 blank output cycles (de=0, syncs inactive, x=99 held); next emission x=100,y=3, de=1; frame period extends to 420005.
5. Small parameters H=4/1/2/1, V=2/1/1/1, H_POL=1, V_POL=1 -> de pattern 1111 0000 per line for y=0..1, then y=2..4 de=0; hsync=1 at x=5..6; vsync=1 only on y=3; vc wraps to 0 after y=4, frame_start every 40 cycles; frame_count wraps 255->0 after 256 frames.
6. rst asserted mid-frame at x=300,y=200 -> next output cycle all reset values; after release first emission is x=0,y=0 with frame_start=1 and frame_count=1.
